// File: rtl/adder_seq_ctrl.sv
// Sequential multi-byte adder controller: two round-robin requesters share one
// external 8-bit adder, one byte per cycle from LSB to MSB.
module adder_seq_ctrl #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req,
   input  logic [8*WORDS-1:0]   op_a0,
   input  logic [8*WORDS-1:0]   op_b0,
   input  logic [8*WORDS-1:0]   op_a1,
   input  logic [8*WORDS-1:0]   op_b1,
   output logic [1:0]           ack,
   output logic [1:0]           done,
   output logic [8*WORDS-1:0]   result,
   output logic                 cout,
   output logic                 busy,
   output logic [7:0]           add_a,
   output logic [7:0]           add_b,
   output logic                 add_cin,
   input  logic [7:0]           add_s,
   input  logic                 add_cout,
   output logic [15:0]          txn_count
);
   localparam int W  = 8 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d, cout_q, cout_d;
   logic            win_q, win_d, prio_q, prio_d;
   logic [1:0]      ack_q, ack_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            grant_w;

   // prio_q names the requester that wins a tie; it always points away from the last grant
   assign grant_w = (req == 2'b11) ? prio_q : req[1];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      win_d   = win_q;
      prio_d  = prio_q;
      ack_d   = 2'b00;
      cnt_d   = cnt_q;
      done    = 2'b00;
      add_a   = 8'h00;
      add_b   = 8'h00;
      add_cin = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               win_d   = grant_w;
               prio_d  = ~grant_w;
               ack_d   = grant_w ? 2'b10 : 2'b01;
               a_d     = grant_w ? op_a1 : op_a0;
               b_d     = grant_w ? op_b1 : op_b0;
               idx_d   = '0;
               carry_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            add_a   = a_q[{idx_q, 3'b000} +: 8];
            add_b   = b_q[{idx_q, 3'b000} +: 8];
            add_cin = carry_q;
            res_d[{idx_q, 3'b000} +: 8] = add_s;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(WORDS - 1)) begin
               cout_d  = add_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = win_q ? 2'b10 : 2'b01;
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         win_q   <= 1'b0;
         prio_q  <= 1'b0;
         ack_q   <= 2'b00;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         win_q   <= win_d;
         prio_q  <= prio_d;
         ack_q   <= ack_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack       = ack_q;
   assign result    = res_q;
   assign cout      = cout_q;
   assign busy      = (state_q != IDLE);
   assign txn_count = cnt_q;
endmodule
